dmem_mmio_bank: RTL and testbench
=================================

Name: dmem_mmio_bank

Overview:
- Parametrised data memory with a memory-mapped I/O window.
- Successor to the fixed two-input / three-output DMEM: it adds a configurable input and output channel count and widths, byte-enable writes, and input synchronisers.
- It also adds sticky change-detect flags with write-1-to-clear, a maskable interrupt, and async active-low reset.
- It sits on the CPU data port; `ask_addr[31]` selects I/O, otherwise the internal RAM.

Parameters:
- MEM_AW, 14, RAM word-address bits; RAM depth is 2^MEM_AW words of 32 bits.
- N_IN, 2, number of input channels (1..16).
- IN_W, 8, input channel width (1..32).
- N_OUT, 3, number of output registers (1..16).
- OUT_W, 16, output register width (1..32).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write strobe for `ask_addr`.
- be  in  4  byte enables; `be[k]` covers `wdata[8k+7:8k]`.
- ask_addr  in  32  write address and RAM read address.
- fetch_addr  in  32  read-select address; the CPU drives the previous cycle's `ask_addr`.
- wdata  in  32  write data.
- rdata  out  32  read data.
- in_data  in  N_IN*IN_W  asynchronous input channels; channel i is at `[i*IN_W +: IN_W]`.
- out_data  out  N_OUT*OUT_W  output registers, concatenated the same way.
- irq  out  1  level interrupt, equal to `|(chg_flags & irq_en)`, registered.

Behaviour:
- Region select:
  - `ask_addr[31]=0` selects RAM; `ask_addr[31]=1` selects I/O.
  - An I/O write never writes RAM.
  - RAM writes are gated `we & ~ask_addr[31]`.
- RAM:
  - Addressed by `ask_addr[MEM_AW+1:2]`.
  - Synchronous read with 1-cycle latency: `ram_q` is registered from `ask_addr` every cycle.
  - Byte-granular write; read-before-write (`ram_q` returns old data on a same-address write).
  - RAM contents are not reset.
- rdata:
  - Combinational mux on `fetch_addr[31]`: if 1, the I/O read value at `fetch_addr[7:2]`; else `ram_q`.
- I/O map (offset = `addr[7:0]`, word-aligned):
  - 0x00+4i, IN[i], read-only. Synchronised value, zero-extended to 32 bits.
  - 0x40+4j, OUT[j], read/write. Byte-enable write; bits at or above OUT_W are ignored on write and read as 0.
  - 0x80, STATUS, read/W1C. Bits `[N_IN-1:0]` are the change flags.
  - 0x84, IRQ_EN, read/write. Bits `[N_IN-1:0]`; the `be` bytes apply.
  - 0x88, CYCLE, read-only. Present only with the optional feature.
- Unmapped offsets, and channel indices ≥N_IN or ≥N_OUT: writes are ignored and reads return 0.
- I/O writes are ignored unless `we=1`; `be=0` is a no-op.
- Input path per channel:
  - Two-flop synchroniser `s1`, `s2`, then `prev` ← `s2`.
  - IN[i] reads `s2`. A change on `in_data` before edge k is readable after edge k+1.
  - The change flag sets at the edge where `s2 != prev`, i.e. edge k+2.
- STATUS W1C:
  - Writing 1 with `be[0]`/`be[1]` covering the bit clears it; writing 0 has no effect.
  - A set condition in the same cycle as a clear: set wins, so the flag stays 1.
- irq is registered: it asserts one edge after a flag and its enable are both 1, and deasserts one edge after the clear.
- Reset (async assert, released synchronously by the system): `out_data`=0, `irq_en`=0, `chg_flags`=0, `irq`=0, `s1`/`s2`/`prev`=0, `ram_q`=0, CYCLE=0.
- Reset mid-write: the write is lost, and I/O registers read reset values after release.

Optional Feature:
- Macro: DMEM_CYCLE_CNT_EN.
- Defined: a 32-bit free-running CYCLE counter.
  - Increments every clock after reset and wraps 0xFFFFFFFF→0.
  - Readable at 0x88; writes are ignored.
- Undefined: no counter logic; 0x88 reads 0.

Test Plan:
- Reset with `rst_n` held low for 3 cycles, then release → `out_data`=0, `irq`=0, STATUS reads 0, OUT[0..2] read 0.
- RAM test: write 0xDEADBEEF to 0x00000010 with `be`=0xF, then write 0x000000AA with `be`=0x1 → read 0x00000010 returns 0xDEADBEAA one cycle after `ask_addr`; no change on `out_data`.
- Output test: write 0x12345678 to 0x80000044 with `be`=0xF → `out_data[31:16]`=0x5678, OUT[1] reads 0x00005678, RAM word at index 0x11 unchanged.
- Input and interrupt: IRQ_EN=0x1, then `in_data` ch0 0x00→0x5A → IN[0] reads 0x5A after 2 edges, STATUS=0x1 at edge 3, `irq`=1 at edge 4.
  - Then write STATUS=0x1 → `irq`=0 one edge after the flag clears.
- Simultaneous events: W1C STATUS bit0 in the same cycle ch0 changes again → bit0 remains 1.
  - Unmapped read at 0x800000F0 returns 0; with DMEM_CYCLE_CNT_EN, two CYCLE reads N cycles apart differ by N.

Source files
------------

// File: rtl/dmem_mmio_bank.sv
// Data RAM with a memory-mapped I/O window: synchronised inputs, output registers,
// W1C change flags and a maskable interrupt. Define DMEM_CYCLE_CNT_EN to add a CYCLE counter at 0x88.
module dmem_mmio_bank #(
    parameter int MEM_AW = 14,
    parameter int N_IN   = 2,
    parameter int IN_W   = 8,
    parameter int N_OUT  = 3,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [31:0]              ask_addr,
    input  logic [31:0]              fetch_addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    input  logic [N_IN*IN_W-1:0]     in_data,
    output logic [N_OUT*OUT_W-1:0]   out_data,
    output logic                     irq
);

    localparam int DEPTH = 1 << MEM_AW;

    localparam logic [5:0] IDX_STATUS = 6'd32;
    localparam logic [5:0] IDX_IRQ_EN = 6'd33;

    logic [31:0]       be_mask;
    logic              ram_we;
    logic              io_we;
    logic [5:0]        wr_idx;
    logic [5:0]        rd_idx;
    logic [MEM_AW-1:0] ram_idx;

    assign be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign ram_we  = we & ~ask_addr[31];
    assign io_we   = we & ask_addr[31] & (|be);
    assign wr_idx  = ask_addr[7:2];
    assign rd_idx  = fetch_addr[7:2];
    assign ram_idx = ask_addr[MEM_AW+1:2];

    // ------------------------------------------------------------------
    // RAM: byte-enable write, registered read (old data on same-address write)
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH];
    logic [31:0] ram_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[ram_idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_q <= '0;
        end else begin
            ram_q <= mem[ram_idx];
        end
    end

    // ------------------------------------------------------------------
    // Input channels: two-flop synchroniser plus a history stage for change detect
    // ------------------------------------------------------------------
    logic [IN_W-1:0] s1_q   [N_IN];
    logic [IN_W-1:0] s2_q   [N_IN];
    logic [IN_W-1:0] prev_q [N_IN];
    logic [N_IN-1:0] chg_set;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_in
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q[gi]   <= '0;
                    s2_q[gi]   <= '0;
                    prev_q[gi] <= '0;
                end else begin
                    s1_q[gi]   <= in_data[gi*IN_W +: IN_W];
                    s2_q[gi]   <= s1_q[gi];
                    prev_q[gi] <= s2_q[gi];
                end
            end
            assign chg_set[gi] = (s2_q[gi] != prev_q[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Change flags (W1C, set has priority), interrupt enable, registered irq
    // ------------------------------------------------------------------
    logic [N_IN-1:0] flags_q, flags_d;
    logic [N_IN-1:0] irq_en_q, irq_en_d;
    logic [N_IN-1:0] wr_bits;
    logic [N_IN-1:0] wr_sel;
    logic            irq_q, irq_d;

    assign wr_bits = wdata[N_IN-1:0];
    assign wr_sel  = be_mask[N_IN-1:0];

    always_comb begin
        flags_d  = flags_q;
        irq_en_d = irq_en_q;
        if (io_we && wr_idx == IDX_STATUS) begin
            flags_d = flags_q & ~(wr_bits & wr_sel);
        end
        flags_d = flags_d | chg_set;
        if (io_we && wr_idx == IDX_IRQ_EN) begin
            irq_en_d = (irq_en_q & ~wr_sel) | (wr_bits & wr_sel);
        end
        irq_d = |(flags_q & irq_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q  <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;

    // ------------------------------------------------------------------
    // Output registers: byte-enable write, bits above OUT_W are dropped
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] out_q [N_OUT];
    logic [OUT_W-1:0] out_d [N_OUT];

    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_out
            always_comb begin
                out_d[gi] = out_q[gi];
                if (io_we && wr_idx == 6'(16 + gi)) begin
                    out_d[gi] = (out_q[gi] & ~be_mask[OUT_W-1:0]) |
                                (wdata[OUT_W-1:0] & be_mask[OUT_W-1:0]);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q[gi] <= '0;
                end else begin
                    out_q[gi] <= out_d[gi];
                end
            end

            assign out_data[gi*OUT_W +: OUT_W] = out_q[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Optional free-running cycle counter
    // ------------------------------------------------------------------
    logic [31:0] cycle_rd;
`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_rd = cycle_q;
`else
    assign cycle_rd = '0;
`endif

    // ------------------------------------------------------------------
    // I/O read map, one entry per word offset; unmapped words read 0
    // ------------------------------------------------------------------
    logic [31:0] io_words [64];

    generate
        for (gi = 0; gi < 64; gi++) begin : g_map
            if (gi < N_IN) begin : g_rd_in
                assign io_words[gi] = 32'(s2_q[gi]);
            end else if (gi >= 16 && gi < 16 + N_OUT) begin : g_rd_out
                assign io_words[gi] = 32'(out_q[gi-16]);
            end else if (gi == 32) begin : g_rd_status
                assign io_words[gi] = 32'(flags_q);
            end else if (gi == 33) begin : g_rd_irq_en
                assign io_words[gi] = 32'(irq_en_q);
            end else if (gi == 34) begin : g_rd_cycle
                assign io_words[gi] = cycle_rd;
            end else begin : g_rd_none
                assign io_words[gi] = '0;
            end
        end
    endgenerate

    assign rdata = fetch_addr[31] ? io_words[rd_idx] : ram_q;

    // Address and data bits outside the decoded ranges are intentionally ignored.
    logic unused_ok;
    assign unused_ok = &{1'b0, ask_addr, fetch_addr, wdata, be_mask};

endmodule

// File: tb/tb_dmem_mmio_bank.sv
// Scoreboard bench for dmem_mmio_bank: RAM, output registers, input change flags,
// W1C priority, interrupt timing, unmapped reads, reset and the optional CYCLE counter.
module tb_dmem_mmio_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [3:0]  be;
    logic [31:0] ask_addr;
    logic [31:0] fetch_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] in_data;
    logic [47:0] out_data;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    logic [31:0] mdl_ram [int];
    logic [15:0] mdl_out [3];

    always #5 clk = ~clk;

    dmem_mmio_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .be         (be),
        .ask_addr   (ask_addr),
        .fetch_addr (fetch_addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .in_data    (in_data),
        .out_data   (out_data),
        .irq        (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s got=%08h", tag, got);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) r[8*k +: 8] = nw[8*k +: 8];
        end
        return r;
    endfunction

    // Drive a write for one cycle and update the reference model.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] b);
        int j;
        ask_addr = addr;
        wdata    = data;
        be       = b;
        we       = 1'b1;
        if (!addr[31]) begin
            mdl_ram[int'(addr[15:2])] = merge(mdl_ram.exists(int'(addr[15:2])) ?
                                              mdl_ram[int'(addr[15:2])] : 32'h0, data, b);
        end else if (addr[7:0] >= 8'h40 && addr[7:0] <= 8'h48) begin
            j = int'(addr[7:2]) - 16;
            mdl_out[j] = merge({16'h0, mdl_out[j]}, data, b) & 32'h0000FFFF;
        end
        @(negedge clk);
        we = 1'b0;
        be = 4'h0;
    endtask

    // Full read transaction: present ask_addr, one cycle later present fetch_addr.
    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        ask_addr = addr;
        we       = 1'b0;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        fetch_addr = addr;
        #1;
        chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    endtask

    // Combinational I/O peek of current register state.
    task automatic peek(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        fetch_addr = addr;
        #1;
        chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c0;
        rst_n      = 1'b0;
        we         = 1'b0;
        be         = 4'h0;
        ask_addr   = 32'h0;
        fetch_addr = 32'h0;
        wdata      = 32'h0;
        in_data    = 16'h0;
        for (int j = 0; j < 3; j++) mdl_out[j] = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_out_data_lo", out_data[31:0], 32'h0);
        chk("rst_out_data_hi", {16'h0, out_data[47:32]}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        peek("rst_ram_q", 32'h0000_0000, 32'h0);
        peek("rst_status", 32'h8000_0080, 32'h0);
        peek("rst_out0", 32'h8000_0040, 32'h0);
        peek("rst_out1", 32'h8000_0044, 32'h0);
        peek("rst_out2", 32'h8000_0048, 32'h0);
        @(negedge clk);

        // RAM byte-enable writes
        wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        wr(32'h0000_0010, 32'h0000_00AA, 4'h1);
        rd("ram_be", 32'h0000_0010, mdl_ram[4]);
        chk("ram_no_out", out_data[31:0], 32'h0);
        wr(32'h0000_0044, 32'h0BAD_F00D, 4'hF);
        wr(32'h0000_0020, 32'h1122_3344, 4'hA);
        rd("ram_be_hi", 32'h0000_0020, mdl_ram[8]);

        // Output registers
        wr(32'h8000_0044, 32'h1234_5678, 4'hF);
        chk("out1_pins", {16'h0, out_data[31:16]}, {16'h0, mdl_out[1]});
        rd("out1_read", 32'h8000_0044, {16'h0, mdl_out[1]});
        rd("ram_11_kept", 32'h0000_0044, mdl_ram[17]);
        wr(32'h8000_0040, 32'hAABB_CCDD, 4'h2);
        rd("out0_byte1", 32'h8000_0040, {16'h0, mdl_out[0]});
        wr(32'h8000_0048, 32'hFFFF_FFFF, 4'h0);
        rd("out2_be0", 32'h8000_0048, {16'h0, mdl_out[2]});
        wr(32'h8000_004C, 32'hFFFF_FFFF, 4'hF);
        rd("out3_unmapped", 32'h8000_004C, 32'h0);
        rd("in2_unmapped", 32'h8000_0008, 32'h0);
        rd("unmapped_f0", 32'h8000_00F0, 32'h0);

        // Input change detect and interrupt timing
        wr(32'h8000_0084, 32'h0000_0001, 4'h1);
        peek("irq_en_rb", 32'h8000_0084, 32'h1);
        in_data[7:0] = 8'h5A;
        @(negedge clk);
        peek("in0_edge1", 32'h8000_0000, 32'h0);
        @(negedge clk);
        peek("in0_edge2", 32'h8000_0000, 32'h5A);
        peek("status_edge2", 32'h8000_0080, 32'h0);
        chk("irq_edge2", {31'h0, irq}, 32'h0);
        @(negedge clk);
        peek("status_edge3", 32'h8000_0080, 32'h1);
        chk("irq_edge3", {31'h0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_edge4", {31'h0, irq}, 32'h1);
        wr(32'h8000_0080, 32'h0000_0001, 4'h1);
        peek("status_w1c", 32'h8000_0080, 32'h0);
        chk("irq_w1c_lag", {31'h0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // W1C collides with a fresh set condition: set wins
        in_data[7:0] = 8'h11;
        @(negedge clk);
        in_data[7:0] = 8'h22;
        @(negedge clk);
        @(negedge clk);
        peek("status_set2", 32'h8000_0080, 32'h1);
        wr(32'h8000_0080, 32'h0000_0001, 4'h1);
        peek("status_set_wins", 32'h8000_0080, 32'h1);
        wr(32'h8000_0080, 32'h0000_0001, 4'h1);
        peek("status_clr2", 32'h8000_0080, 32'h0);
        wr(32'h8000_0080, 32'h0000_0001, 4'h0);
        peek("in0_final", 32'h8000_0000, 32'h22);

`ifdef DMEM_CYCLE_CNT_EN
        fetch_addr = 32'h8000_0088;
        #1;
        c0 = rdata;
        repeat (5) @(negedge clk);
        peek("cycle_delta", 32'h8000_0088, c0 + 32'd5);
`else
        c0 = 32'h0;
        peek("cycle_absent", 32'h8000_0088, c0);
`endif

        // Reset asserted during a write: write lost, registers back to reset
        @(negedge clk);
        ask_addr = 32'h8000_0048;
        wdata    = 32'h0000_BEEF;
        be       = 4'hF;
        we       = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        we    = 1'b0;
        be    = 4'h0;
        rst_n = 1'b1;
        chk("midrst_out_lo", out_data[31:0], 32'h0);
        chk("midrst_out_hi", {16'h0, out_data[47:32]}, 32'h0);
        peek("midrst_irq_en", 32'h8000_0084, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
